// File: rtl/mfu_pkg.sv
// rtl/mfu_pkg.sv - shared encodings and defaults for the MFU op sequencer
package mfu_pkg;
    localparam int VRF_AWIDTH_DEF   = 10;
    localparam int LEN_WIDTH_DEF    = 8;
    localparam int MAX_INFLIGHT_DEF = 4;

    typedef enum logic [1:0] {
        OP_ACTIVATION = 2'b00,
        OP_ELT_ADD    = 2'b01,
        OP_ELT_MUL    = 2'b10,
        OP_BYPASS     = 2'b11
    } mfu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } seq_state_e;
endpackage

// File: rtl/mfu_op_sequencer_if.sv
// rtl/mfu_op_sequencer_if.sv - instruction handshake between decoder and sequencer
interface mfu_op_sequencer_if
    import mfu_pkg::*;
#(
    parameter int VRF_AWIDTH = VRF_AWIDTH_DEF,
    parameter int LEN_WIDTH  = LEN_WIDTH_DEF
);
    logic                  instr_valid;
    logic                  instr_ready;
    logic [1:0]            instr_op;
    logic                  instr_act;
    logic [VRF_AWIDTH-1:0] instr_rd_base;
    logic [VRF_AWIDTH-1:0] instr_wr_base;
    logic [LEN_WIDTH-1:0]  instr_len;

    modport master (
        output instr_valid, instr_op, instr_act, instr_rd_base, instr_wr_base, instr_len,
        input  instr_ready
    );

    modport slave (
        input  instr_valid, instr_op, instr_act, instr_rd_base, instr_wr_base, instr_len,
        output instr_ready
    );
endinterface

// File: rtl/mfu_inflight_tracker.sv
// rtl/mfu_inflight_tracker.sv - in-flight element counter with full flag and spurious-result detect
module mfu_inflight_tracker
    import mfu_pkg::*;
#(
    parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF
) (
    input  logic                                clk,
    input  logic                                resetn,
    input  logic                                clear,
    input  logic                                issue,
    input  logic                                result,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0]   count,
    output logic                                full,
    output logic                                retire,
    output logic                                err_spurious
);
    localparam int IW = $clog2(MAX_INFLIGHT + 1);

    assign full   = (count == IW'(MAX_INFLIGHT));
    assign retire = result && (count != '0);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count        <= '0;
            err_spurious <= 1'b0;
        end else begin
            // a result with nothing outstanding is flagged but never moves the count
            if (result && (count == '0))
                err_spurious <= 1'b1;
            if (clear)
                count <= '0;
            else if (issue && !retire)
                count <= count + IW'(1);
            else if (!issue && retire)
                count <= count - IW'(1);
        end
    end
endmodule

// File: rtl/mfu_op_sequencer.sv
// rtl/mfu_op_sequencer.sv - issues one vector instruction element-by-element to an MFU and tracks write-back
module mfu_op_sequencer
    import mfu_pkg::*;
#(
    parameter int VRF_AWIDTH   = VRF_AWIDTH_DEF,
    parameter int LEN_WIDTH    = LEN_WIDTH_DEF,
    parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF
) (
    input  logic                  clk,
    input  logic                  resetn,
    mfu_op_sequencer_if.slave     instr,
    input  logic                  issue_stall,
    output logic [1:0]            mfu_operation,
    output logic                  mfu_activation_type,
    output logic                  mfu_in_data_available,
    output logic                  mfu_vrf_read_enable,
    output logic [VRF_AWIDTH-1:0] mfu_vrf_addr_read,
    input  logic                  mfu_out_data_available,
    output logic                  wb_valid,
    output logic [VRF_AWIDTH-1:0] wb_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  err_spurious
);
    localparam int IW = $clog2(MAX_INFLIGHT + 1);

    seq_state_e            state, state_nx;
    mfu_op_e               op_q;
    logic                  act_q;
    logic [VRF_AWIDTH-1:0] rd_base_q, wr_base_q;
    logic [LEN_WIDTH-1:0]  len_q, issued, retired;
    logic                  accept, issue, full, retire;
    logic [IW-1:0]         inflight;

    assign accept = instr.instr_valid && instr.instr_ready;

    always_comb begin
        state_nx          = state;
        instr.instr_ready = 1'b0;
        issue             = 1'b0;
        case (state)
            ST_IDLE: begin
                instr.instr_ready = 1'b1;
                if (instr.instr_valid)
                    state_nx = (instr.instr_len == '0) ? ST_DONE : ST_ISSUE;
            end
            ST_ISSUE: begin
                issue = !issue_stall && !full;
                if (issue && (issued == len_q - LEN_WIDTH'(1)))
                    state_nx = ST_DRAIN;
            end
            ST_DRAIN: begin
                if ((retired == len_q) && (inflight == '0))
                    state_nx = ST_DONE;
            end
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    assign mfu_in_data_available = issue;
    assign mfu_vrf_read_enable   = issue;
    assign mfu_vrf_addr_read     = rd_base_q + VRF_AWIDTH'(issued);
    assign mfu_operation         = op_q;
    assign mfu_activation_type   = act_q;
    assign busy                  = (state != ST_IDLE);
    assign done                  = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            op_q      <= OP_ACTIVATION;
            act_q     <= 1'b0;
            rd_base_q <= '0;
            wr_base_q <= '0;
            len_q     <= '0;
            issued    <= '0;
            retired   <= '0;
            wb_valid  <= 1'b0;
            wb_addr   <= '0;
        end else begin
            state    <= state_nx;
            wb_valid <= retire;
            if (accept) begin
                op_q      <= mfu_op_e'(instr.instr_op);
                act_q     <= instr.instr_act;
                rd_base_q <= instr.instr_rd_base;
                wr_base_q <= instr.instr_wr_base;
                len_q     <= instr.instr_len;
                issued    <= '0;
                retired   <= '0;
            end else begin
                if (issue)
                    issued <= issued + LEN_WIDTH'(1);
                if (retire)
                    retired <= retired + LEN_WIDTH'(1);
            end
            // results come back in issue order, so the retire count is the element index
            if (retire)
                wb_addr <= wr_base_q + VRF_AWIDTH'(retired);
        end
    end

    mfu_inflight_tracker #(
        .MAX_INFLIGHT (MAX_INFLIGHT)
    ) u_trk (
        .clk          (clk),
        .resetn       (resetn),
        .clear        (accept),
        .issue        (issue),
        .result       (mfu_out_data_available),
        .count        (inflight),
        .full         (full),
        .retire       (retire),
        .err_spurious (err_spurious)
    );
endmodule
